data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
- Load/store requester for the pipeline's data memory; the initiator end of the memory's read/write port pair.
- Accepts one load or store per handshake from the execute stage and splits 32-bit accesses into two 16-bit word accesses.
- Drives one memory read port and one memory write port, then returns load data or a store acknowledge through a valid/ready response channel.
- Sits between the execute/memory pipeline stage and the data memory.

Parameters:
ADDR_W, 9, word address width (512 words)
DATA_W, 16, memory word width; the request data width is 2*DATA_W

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_write  input  1  1 = store, 0 = load
req_size  input  1  0 = 16-bit access, 1 = 32-bit access
req_addr  input  ADDR_W  word address
req_wdata  input  2*DATA_W  store data; low word is stored at req_addr
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts the response
rsp_rdata  output  2*DATA_W  load data; 0 for stores
rsp_err  output  1  request was rejected (only with ALIGN_CHECK_EN)
mem_rd_addr  output  ADDR_W  memory read address
mem_rd_data  input  DATA_W  combinational read data from memory
mem_wr_addr  output  ADDR_W  memory write address
mem_wr_data  output  DATA_W  memory write data
mem_wr_enable  output  1  memory write strobe

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_wr_enable=0, mem_rd_addr=0, mem_wr_addr=0, mem_wr_data=0.
  - req_ready=1 once state is IDLE.
- States:
  - IDLE -> LO on req_valid&&req_ready.
  - LO -> HI if the latched size is 32-bit, otherwise LO -> RESP.
  - HI -> RESP.
  - RESP -> IDLE on rsp_ready.
- req_ready = (state==IDLE), combinational. No request is accepted in any other state; req_* is ignored outside IDLE.
- On accept, latch write, size, addr and wdata into internal registers. req_* may change after the accept cycle.
- LO state:
  - mem_rd_addr = mem_wr_addr = latched addr.
  - Store: mem_wr_enable=1, mem_wr_data = wdata[15:0].
  - Load: mem_wr_enable=0, and mem_rd_data is captured into rdata[15:0] at the end of the cycle.
- HI state:
  - Address = (latched addr + 1) mod 2^ADDR_W; 511 wraps to 0.
  - Store writes wdata[31:16]; load captures rdata[31:16].
- mem_wr_enable is 1 only during the LO/HI cycle of a store: exactly one cycle per word, never in IDLE or RESP.
- A 16-bit load returns rdata[31:16]=0.
- RESP state:
  - rsp_valid=1 with rsp_rdata and rsp_err stable until rsp_ready is sampled high.
  - Store: rsp_rdata=0.
  - Leaving RESP clears rsp_valid.
- Latency from the accept edge:
  - 16-bit: rsp_valid on the 2nd rising edge after accept.
  - 32-bit: rsp_valid on the 3rd rising edge after accept.
  - With rsp_ready held at 1, throughput is one request per 3 cycles (16-bit) or 4 cycles (32-bit).
- Back-pressure: rsp_ready=0 holds the block in RESP indefinitely; req_ready stays 0 for that time.
- Reset mid-operation: any state returns to IDLE immediately. No write strobe occurs after reset asserts, a partially completed 32-bit store is not resumed, and no response is issued.
- In idle, mem addresses hold their last values and mem_wr_enable=0.

Optional Feature:
ALIGN_CHECK_EN
- Defined:
  - A 32-bit request with req_addr[0]=1 goes IDLE -> RESP directly.
  - No memory write, rsp_err=1, rsp_rdata=0.
  - All other requests set rsp_err=0.
- Undefined:
  - rsp_err is tied to 0.
  - Odd 32-bit accesses proceed normally using the wrap rule.

Test Plan:
1. After reset release, 16-bit store addr=0x010, wdata=0x0000_BEEF, rsp_ready=1 -> one cycle with mem_wr_enable=1, mem_wr_addr=0x010, mem_wr_data=0xBEEF; rsp_valid on the 2nd edge; rsp_rdata=0.
2. 32-bit load addr=0x020 with the memory model holding [0x020]=0x1234 and [0x021]=0xABCD -> mem_rd_addr 0x020 then 0x021; rsp_rdata=0xABCD_1234 on the 3rd edge; no write strobe.
3. 32-bit store addr=0x1FF, wdata=0x5555_AAAA (ALIGN_CHECK_EN undefined) -> writes 0xAAAA to 0x1FF, then 0x5555 to 0x000 (wrap).
4. Load completes while rsp_ready is held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
5. Assert reset during the HI cycle of a 32-bit store at 0x040 -> only [0x040] written; no strobe for 0x041; rsp_valid=0; req_ready=1 after release.
6. With ALIGN_CHECK_EN defined, 32-bit store addr=0x033 -> no mem_wr_enable; rsp_valid on the 1st edge after accept with rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Load/store requester for the data memory: splits 32-bit accesses into two 16-bit word cycles.
// Optional feature ALIGN_CHECK_EN rejects odd-address 32-bit requests with rsp_err.
module data_mem_lsu #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic                  req_size,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [2*DATA_W-1:0]   rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_W-1:0]     mem_rd_addr,
   input  logic [DATA_W-1:0]     mem_rd_data,
   output logic [ADDR_W-1:0]     mem_wr_addr,
   output logic [DATA_W-1:0]     mem_wr_data,
   output logic                  mem_wr_enable
);

   typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

   state_t              state_q;
   logic                write_q;
   logic                size_q;
   logic                wrEn_q;
   logic                rspValid_q;
   logic [ADDR_W-1:0]   memAddr_q;
   logic [DATA_W-1:0]   wrData_q;
   logic [DATA_W-1:0]   wdataHi_q;
   logic [2*DATA_W-1:0] rdata_q;
   logic                accept;
   logic                misaligned;

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid && req_ready;

`ifdef ALIGN_CHECK_EN
   logic err_q;
   assign misaligned = req_size && req_addr[0];
   assign rsp_err    = err_q;
`else
   assign misaligned = 1'b0;
   assign rsp_err    = 1'b0;
`endif

   assign rsp_valid     = rspValid_q;
   assign rsp_rdata     = rdata_q;
   assign mem_rd_addr   = memAddr_q;
   assign mem_wr_addr   = memAddr_q;
   assign mem_wr_data   = wrData_q;
   assign mem_wr_enable = wrEn_q;

   // Memory-side outputs are registered one state ahead, so the strobe and
   // address for LO/HI are already stable when the state is entered.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         write_q    <= 1'b0;
         size_q     <= 1'b0;
         wrEn_q     <= 1'b0;
         rspValid_q <= 1'b0;
         memAddr_q  <= '0;
         wrData_q   <= '0;
         wdataHi_q  <= '0;
         rdata_q    <= '0;
`ifdef ALIGN_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  write_q   <= req_write;
                  size_q    <= req_size;
                  wdataHi_q <= req_wdata[2*DATA_W-1:DATA_W];
                  rdata_q   <= '0;
`ifdef ALIGN_CHECK_EN
                  err_q     <= misaligned;
`endif
                  if (misaligned) begin
                     state_q    <= RESP;
                     rspValid_q <= 1'b1;
                  end else begin
                     state_q   <= LO;
                     memAddr_q <= req_addr;
                     wrData_q  <= req_wdata[DATA_W-1:0];
                     wrEn_q    <= req_write;
                  end
               end
            end
            LO: begin
               if (!write_q) begin
                  rdata_q[DATA_W-1:0] <= mem_rd_data;
               end
               if (size_q) begin
                  state_q   <= HI;
                  memAddr_q <= memAddr_q + ADDR_W'(1);
                  wrData_q  <= wdataHi_q;
                  wrEn_q    <= write_q;
               end else begin
                  state_q    <= RESP;
                  wrEn_q     <= 1'b0;
                  rspValid_q <= 1'b1;
               end
            end
            HI: begin
               if (!write_q) begin
                  rdata_q[2*DATA_W-1:DATA_W] <= mem_rd_data;
               end
               state_q    <= RESP;
               wrEn_q     <= 1'b0;
               rspValid_q <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q    <= IDLE;
                  rspValid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: directed requests against a 512-word memory model,
// with expected writes and responses queued by the driver and checked by monitors.
module tb_data_mem_lsu;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_size;
   logic [8:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [8:0]  mem_rd_addr;
   logic [15:0] mem_rd_data;
   logic [8:0]  mem_wr_addr;
   logic [15:0] mem_wr_data;
   logic        mem_wr_enable;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } rsp_t;

   typedef struct {
      logic [8:0]  addr;
      logic [15:0] data;
   } wr_t;

   rsp_t        expQ[$];
   wr_t         wrQ[$];
   rsp_t        cur;
   logic        haveRsp = 1'b0;
   logic [15:0] mem [0:511];
   int          cyc = 0;
   int          acceptCyc = 0;
   int          total = 0;
   int          bad = 0;

   data_mem_lsu #(.ADDR_W(9), .DATA_W(16)) dut (
      .clock(clock),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_size(req_size),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data),
      .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data),
      .mem_wr_enable(mem_wr_enable)
   );

   // Free-running clock and a cycle counter used to measure response latency.
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Memory model: combinational read, write on the rising edge.
   assign mem_rd_data = mem[mem_rd_addr];

   always @(posedge clock) begin
      if (mem_wr_enable) mem[mem_wr_addr] <= mem_wr_data;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pushRsp(input logic [31:0] rdata, input logic err, input int lat);
      rsp_t r;
      r.rdata = rdata;
      r.err   = err;
      r.lat   = lat;
      expQ.push_back(r);
   endtask

   task automatic pushWr(input logic [8:0] addr, input logic [15:0] data);
      wr_t w;
      w.addr = addr;
      w.data = data;
      wrQ.push_back(w);
   endtask

   // Write monitor: every strobe observed must match the next expected write.
   always @(negedge clock) begin
      if (reset && mem_wr_enable) begin
         if (wrQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedWrite: got addr %h data %h expected none", mem_wr_addr, mem_wr_data);
         end else begin
            wr_t w;
            w = wrQ.pop_front();
            checkOutput("wrAddr", {23'd0, mem_wr_addr}, {23'd0, w.addr});
            checkOutput("wrData", {16'd0, mem_wr_data}, {16'd0, w.data});
         end
      end
   end

   // Response monitor: pops on a new response, then checks it stays stable until consumed.
   always @(negedge clock) begin
      if (!reset) begin
         haveRsp = 1'b0;
      end else if (rsp_valid) begin
         if (!haveRsp) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpectedRsp: got rdata %h err %b expected none", rsp_rdata, rsp_err);
            end else begin
               cur = expQ.pop_front();
               haveRsp = 1'b1;
               checkOutput("rspRdata", rsp_rdata, cur.rdata);
               checkOutput("rspErr", {31'd0, rsp_err}, {31'd0, cur.err});
               checkOutput("rspLatency", cyc - acceptCyc, cur.lat);
            end
         end else begin
            checkOutput("rspHold", rsp_rdata, cur.rdata);
         end
         if (rsp_ready) haveRsp = 1'b0;
      end
   end

   // Issues one request when the block is idle and scrambles req_* right after the accept edge.
   task automatic applyStimulus(input logic wr, input logic sz, input logic [8:0] addr, input logic [31:0] wdata);
      int n = 0;
      @(negedge clock);
      while (!req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!req_ready) begin
         total++;
         bad++;
         $display("[TB] FAIL acceptTimeout: got req_ready 0 expected 1");
         return;
      end
      req_valid = 1'b1;
      req_write = wr;
      req_size  = sz;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clock);
      #1;
      acceptCyc = cyc;
      req_valid = 1'b0;
      req_write = ~wr;
      req_size  = ~sz;
      req_addr  = ~addr;
      req_wdata = ~wdata;
   endtask

   task automatic waitIdle();
      int n = 0;
      @(negedge clock);
      while (!(req_ready && !rsp_valid) && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (!(req_ready && !rsp_valid)) begin
         total++;
         bad++;
         $display("[TB] FAIL idleTimeout: got req_ready %b rsp_valid %b expected 1 0", req_ready, rsp_valid);
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
      mem[9'h020] = 16'h1234;
      mem[9'h021] = 16'hABCD;
      mem[9'h050] = 16'h7777;
      reset     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_size  = 1'b0;
      req_addr  = 9'h000;
      req_wdata = 32'h0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("rstReqReady", {31'd0, req_ready}, 32'd1);
      checkOutput("rstRspValid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("rstRspRdata", rsp_rdata, 32'd0);
      checkOutput("rstRspErr", {31'd0, rsp_err}, 32'd0);
      checkOutput("rstWrEn", {31'd0, mem_wr_enable}, 32'd0);
      checkOutput("rstRdAddr", {23'd0, mem_rd_addr}, 32'd0);
      checkOutput("rstWrAddr", {23'd0, mem_wr_addr}, 32'd0);
      checkOutput("rstWrData", {16'd0, mem_wr_data}, 32'd0);

      $display("[TB] 16-bit store");
      pushWr(9'h010, 16'hBEEF);
      pushRsp(32'h0000_0000, 1'b0, 1);
      applyStimulus(1'b1, 1'b0, 9'h010, 32'h0000_BEEF);
      waitIdle();

      $display("[TB] 32-bit load");
      pushRsp(32'hABCD_1234, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 9'h020, 32'h0);
      waitIdle();

      $display("[TB] 32-bit store at top of memory");
`ifdef ALIGN_CHECK_EN
      pushRsp(32'h0000_0000, 1'b1, 0);
`else
      pushWr(9'h1FF, 16'hAAAA);
      pushWr(9'h000, 16'h5555);
      pushRsp(32'h0000_0000, 1'b0, 2);
`endif
      applyStimulus(1'b1, 1'b1, 9'h1FF, 32'h5555_AAAA);
      waitIdle();

`ifdef ALIGN_CHECK_EN
      pushRsp(32'h0000_0000, 1'b1, 0);
`else
      pushRsp(32'h5555_AAAA, 1'b0, 2);
`endif
      applyStimulus(1'b0, 1'b1, 9'h1FF, 32'h0);
      waitIdle();

      $display("[TB] 16-bit load clears upper half");
      pushRsp(32'h0000_ABCD, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 9'h021, 32'h0);
      waitIdle();

      $display("[TB] back-pressure");
      pushRsp(32'h0000_7777, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 9'h050, 32'h0);
      rsp_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         checkOutput("bpReqReady", {31'd0, req_ready}, 32'd0);
      end
      checkOutput("bpRspValid", {31'd0, rsp_valid}, 32'd1);
      @(posedge clock);
      #1;
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("bpIdleReady", {31'd0, req_ready}, 32'd1);
      checkOutput("bpIdleValid", {31'd0, rsp_valid}, 32'd0);

      $display("[TB] reset during second word of a store");
      pushWr(9'h040, 16'h6666);
      applyStimulus(1'b1, 1'b1, 9'h040, 32'h9999_6666);
      @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("midRstWrEn", {31'd0, mem_wr_enable}, 32'd0);
      checkOutput("midRstRspValid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("postRstReady", {31'd0, req_ready}, 32'd1);
      checkOutput("postRstRspValid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("mem040", {16'd0, mem[9'h040]}, 32'h0000_6666);
      checkOutput("mem041", {16'd0, mem[9'h041]}, 32'h0000_0000);

      $display("[TB] odd 32-bit store");
`ifdef ALIGN_CHECK_EN
      pushRsp(32'h0000_0000, 1'b1, 0);
`else
      pushWr(9'h033, 16'h2222);
      pushWr(9'h034, 16'h1111);
      pushRsp(32'h0000_0000, 1'b0, 2);
`endif
      applyStimulus(1'b1, 1'b1, 9'h033, 32'h1111_2222);
      waitIdle();

      $display("[TB] even 32-bit store then load back");
      pushWr(9'h060, 16'hF00D);
      pushWr(9'h061, 16'hCAFE);
      pushRsp(32'h0000_0000, 1'b0, 2);
      applyStimulus(1'b1, 1'b1, 9'h060, 32'hCAFE_F00D);
      waitIdle();
      pushRsp(32'hCAFE_F00D, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 9'h060, 32'h0);
      waitIdle();

      repeat (5) @(negedge clock);
      checkOutput("rspQueueEmpty", expQ.size(), 32'd0);
      checkOutput("wrQueueEmpty", wrQ.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
